// File: rtl/execute_stage_if.sv
// execute_stage_if
//   Bundles the ID/EX-side inputs and EX/MEM latch outputs of the execute
//   stage. Only clk and reset stay outside as plain ports.
//   slave  : the execute stage (consumes *_2_3, forwarding selects, WB data;
//            drives the *_3_4 latch outputs)
//   master : the upstream pipeline / forwarding unit / testbench
interface execute_stage_if #(
    parameter int len = 32,
    parameter int NB  = $clog2(len)
);
    logic            enable;
    logic            flush;
    logic [1:0]      control_muxA;
    logic [1:0]      control_muxB;
    logic [len-1:0]  data_a_2_3;
    logic [len-1:0]  data_b_2_3;
    logic [len-1:0]  sign_ext_2_3;
    logic [4:0]      shamt_2_3;
    logic [NB-1:0]   rt_2_3;
    logic [NB-1:0]   rd_2_3;
    logic [3:0]      alu_ctrl_2_3;
    logic            alu_src_2_3;
    logic            reg_dst_2_3;
    logic            register_write_2_3;
    logic            mem_read_2_3;
    logic            mem_write_2_3;
    logic            mem_to_reg_2_3;
    logic [len-1:0]  write_back_data_4_5;

    logic [len-1:0]  alu_result_3_4;
    logic [len-1:0]  store_data_3_4;
    logic [NB-1:0]   rd_3_4;
    logic            register_write_3_4;
    logic            mem_read_3_4;
    logic            mem_write_3_4;
    logic            mem_to_reg_3_4;

    modport slave (
        input  enable, flush, control_muxA, control_muxB,
        input  data_a_2_3, data_b_2_3, sign_ext_2_3, shamt_2_3,
        input  rt_2_3, rd_2_3, alu_ctrl_2_3, alu_src_2_3, reg_dst_2_3,
        input  register_write_2_3, mem_read_2_3, mem_write_2_3, mem_to_reg_2_3,
        input  write_back_data_4_5,
        output alu_result_3_4, store_data_3_4, rd_3_4,
        output register_write_3_4, mem_read_3_4, mem_write_3_4, mem_to_reg_3_4
    );

    modport master (
        output enable, flush, control_muxA, control_muxB,
        output data_a_2_3, data_b_2_3, sign_ext_2_3, shamt_2_3,
        output rt_2_3, rd_2_3, alu_ctrl_2_3, alu_src_2_3, reg_dst_2_3,
        output register_write_2_3, mem_read_2_3, mem_write_2_3, mem_to_reg_2_3,
        output write_back_data_4_5,
        input  alu_result_3_4, store_data_3_4, rd_3_4,
        input  register_write_3_4, mem_read_3_4, mem_write_3_4, mem_to_reg_3_4
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage
//   EX stage of the 5-stage MIPS pipeline plus the EX/MEM latch.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-high; clears every *_3_4 output
//     ex    - execute_stage_if.slave: ID/EX operands and controls, forwarding
//             selects, WB data in; registered *_3_4 results out
module execute_stage #(
    parameter int len = 32,
    parameter int NB  = $clog2(len)
) (
    input logic             clk,
    input logic             reset,
    execute_stage_if.slave  ex
);

    logic [len-1:0] op_a;
    logic [len-1:0] fwd_b;
    logic [len-1:0] op_b;
    logic [len-1:0] alu_out;
    logic [NB-1:0]  dst;

    logic [len-1:0] alu_result_q, alu_result_d;
    logic [len-1:0] store_data_q, store_data_d;
    logic [NB-1:0]  rd_q, rd_d;
    logic           register_write_q, register_write_d;
    logic           mem_read_q, mem_read_d;
    logic           mem_write_q, mem_write_d;
    logic           mem_to_reg_q, mem_to_reg_d;

    // Forwarding muxes; code 01 takes this stage's own latched result, so a
    // stalled latch keeps feeding the same value back.
    always_comb begin
        op_a = ex.data_a_2_3;
        case (ex.control_muxA)
            2'b01:   op_a = alu_result_q;
            2'b10:   op_a = ex.write_back_data_4_5;
            default: op_a = ex.data_a_2_3;
        endcase
        fwd_b = ex.data_b_2_3;
        case (ex.control_muxB)
            2'b01:   fwd_b = alu_result_q;
            2'b10:   fwd_b = ex.write_back_data_4_5;
            default: fwd_b = ex.data_b_2_3;
        endcase
    end

    assign op_b = ex.alu_src_2_3 ? ex.sign_ext_2_3 : fwd_b;
    assign dst  = ex.reg_dst_2_3 ? ex.rd_2_3 : ex.rt_2_3;

    always_comb begin
        alu_out = '0;
        case (ex.alu_ctrl_2_3)
            4'b0000: alu_out = op_b << ex.shamt_2_3;
            4'b0001: alu_out = op_b >> ex.shamt_2_3;
            4'b0010: alu_out = $signed(op_b) >>> ex.shamt_2_3;
            4'b0011: alu_out = op_b << op_a[4:0];
            4'b0100: alu_out = op_b >> op_a[4:0];
            4'b0101: alu_out = $signed(op_b) >>> op_a[4:0];
            4'b0110: alu_out = op_a + op_b;
            4'b0111: alu_out = op_a - op_b;
            4'b1000: alu_out = op_a & op_b;
            4'b1001: alu_out = op_a | op_b;
            4'b1010: alu_out = op_a ^ op_b;
            4'b1011: alu_out = ~(op_a | op_b);
            4'b1100: alu_out = {{(len-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b1101: alu_out = op_b << 16;
            default: alu_out = '0;
        endcase
    end

    // Latch next-state: hold when not enabled (flush has no effect then),
    // bubble on flush, otherwise load.
    always_comb begin
        alu_result_d     = alu_result_q;
        store_data_d     = store_data_q;
        rd_d             = rd_q;
        register_write_d = register_write_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_to_reg_d     = mem_to_reg_q;
        if (ex.enable) begin
            if (ex.flush) begin
                alu_result_d     = '0;
                store_data_d     = '0;
                rd_d             = '0;
                register_write_d = 1'b0;
                mem_read_d       = 1'b0;
                mem_write_d      = 1'b0;
                mem_to_reg_d     = 1'b0;
            end else begin
                alu_result_d     = alu_out;
                store_data_d     = fwd_b;
                rd_d             = dst;
                register_write_d = ex.register_write_2_3;
                mem_read_d       = ex.mem_read_2_3;
                mem_write_d      = ex.mem_write_2_3;
                mem_to_reg_d     = ex.mem_to_reg_2_3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_q     <= '0;
            store_data_q     <= '0;
            rd_q             <= '0;
            register_write_q <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_to_reg_q     <= 1'b0;
        end else begin
            alu_result_q     <= alu_result_d;
            store_data_q     <= store_data_d;
            rd_q             <= rd_d;
            register_write_q <= register_write_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_to_reg_q     <= mem_to_reg_d;
        end
    end

    assign ex.alu_result_3_4     = alu_result_q;
    assign ex.store_data_3_4     = store_data_q;
    assign ex.rd_3_4             = rd_q;
    assign ex.register_write_3_4 = register_write_q;
    assign ex.mem_read_3_4       = mem_read_q;
    assign ex.mem_write_3_4      = mem_write_q;
    assign ex.mem_to_reg_3_4     = mem_to_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
//   Drives execute_stage through its interface with directed cases and
//   random traffic; a spec-level model predicts the EX/MEM latch contents.
module tb_execute_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_on = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    execute_stage_if bus ();

    execute_stage dut (
        .clk   (clk),
        .reset (rst),
        .ex    (bus)
    );

    // Model of what the EX/MEM latch must hold.
    logic [31:0] exp_alu, exp_store;
    logic [4:0]  exp_rd;
    logic        exp_rw, exp_mr, exp_mw, exp_m2r;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv,
                                         input logic [31:0] prev, input logic [31:0] wb);
        if (sel == 2'd1) return prev;
        if (sel == 2'd2) return wb;
        return regv;
    endfunction

    function automatic logic [31:0] sra_ref(input logic [31:0] v, input int s);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        if (v[31]) return (v >> s) | ~(ones >> s);
        return v >> s;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        int sa;
        sa = int'(a[4:0]);
        case (op)
            4'd0:  return b << sh;
            4'd1:  return b >> sh;
            4'd2:  return sra_ref(b, int'(sh));
            4'd3:  return b << sa;
            4'd4:  return b >> sa;
            4'd5:  return sra_ref(b, sa);
            4'd6:  return a + b;
            4'd7:  return a - b;
            4'd8:  return a & b;
            4'd9:  return a | b;
            4'd10: return a ^ b;
            4'd11: return ~(a | b);
            4'd12: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd13: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] a, fb, b;
        if (rst) begin
            {exp_alu, exp_store, exp_rd, exp_rw, exp_mr, exp_mw, exp_m2r} = '0;
        end else if (bus.enable) begin
            if (bus.flush) begin
                {exp_alu, exp_store, exp_rd, exp_rw, exp_mr, exp_mw, exp_m2r} = '0;
            end else begin
                a  = pick(bus.control_muxA, bus.data_a_2_3, exp_alu, bus.write_back_data_4_5);
                fb = pick(bus.control_muxB, bus.data_b_2_3, exp_alu, bus.write_back_data_4_5);
                b  = bus.alu_src_2_3 ? bus.sign_ext_2_3 : fb;
                exp_alu   = alu_ref(bus.alu_ctrl_2_3, a, b, bus.shamt_2_3);
                exp_store = fb;
                exp_rd    = bus.reg_dst_2_3 ? bus.rd_2_3 : bus.rt_2_3;
                exp_rw    = bus.register_write_2_3;
                exp_mr    = bus.mem_read_2_3;
                exp_mw    = bus.mem_write_2_3;
                exp_m2r   = bus.mem_to_reg_2_3;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cmp_alu",   bus.alu_result_3_4, exp_alu);
            check("cmp_store", bus.store_data_3_4, exp_store);
            check("cmp_rd",    {27'b0, bus.rd_3_4}, {27'b0, exp_rd});
            check("cmp_rw",    {31'b0, bus.register_write_3_4}, {31'b0, exp_rw});
            check("cmp_mr",    {31'b0, bus.mem_read_3_4}, {31'b0, exp_mr});
            check("cmp_mw",    {31'b0, bus.mem_write_3_4}, {31'b0, exp_mw});
            check("cmp_m2r",   {31'b0, bus.mem_to_reg_3_4}, {31'b0, exp_m2r});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.enable = 1'b1;  bus.flush = 1'b0;
        bus.control_muxA = 2'd0;  bus.control_muxB = 2'd0;
        bus.data_a_2_3 = '0;  bus.data_b_2_3 = '0;  bus.sign_ext_2_3 = '0;
        bus.shamt_2_3 = '0;  bus.rt_2_3 = '0;  bus.rd_2_3 = '0;
        bus.alu_ctrl_2_3 = '0;  bus.alu_src_2_3 = 1'b0;  bus.reg_dst_2_3 = 1'b0;
        bus.register_write_2_3 = 1'b0;  bus.mem_read_2_3 = 1'b0;
        bus.mem_write_2_3 = 1'b0;  bus.mem_to_reg_2_3 = 1'b0;
        bus.write_back_data_4_5 = '0;
    endtask

    task automatic rand_in();
        bus.enable = ($urandom_range(0, 99) < 85);
        bus.flush  = ($urandom_range(0, 99) < 10);
        bus.control_muxA = 2'($urandom_range(0, 3));
        bus.control_muxB = 2'($urandom_range(0, 3));
        bus.data_a_2_3 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
        bus.data_b_2_3 = $urandom;
        bus.sign_ext_2_3 = $urandom_range(0, 1) ? 32'hFFFF_8000 | $urandom_range(0, 32767)
                                                : $urandom_range(0, 32767);
        bus.shamt_2_3 = 5'($urandom_range(0, 31));
        bus.rt_2_3 = 5'($urandom_range(0, 31));
        bus.rd_2_3 = 5'($urandom_range(0, 31));
        bus.alu_ctrl_2_3 = 4'($urandom_range(0, 15));
        bus.alu_src_2_3 = 1'($urandom_range(0, 1));
        bus.reg_dst_2_3 = 1'($urandom_range(0, 1));
        bus.register_write_2_3 = 1'($urandom_range(0, 1));
        bus.mem_read_2_3 = 1'($urandom_range(0, 1));
        bus.mem_write_2_3 = 1'($urandom_range(0, 1));
        bus.mem_to_reg_2_3 = 1'($urandom_range(0, 1));
        bus.write_back_data_4_5 = $urandom;
    endtask

    initial begin
        // Reset with every input nonzero.
        rst = 1'b1;
        bus.enable = 1'b1;  bus.flush = 1'b1;
        bus.control_muxA = 2'd1;  bus.control_muxB = 2'd2;
        bus.data_a_2_3 = 32'h1111_1111;  bus.data_b_2_3 = 32'h2222_2222;
        bus.sign_ext_2_3 = 32'h3333_3333;  bus.shamt_2_3 = 5'd7;
        bus.rt_2_3 = 5'd9;  bus.rd_2_3 = 5'd10;  bus.alu_ctrl_2_3 = 4'd6;
        bus.alu_src_2_3 = 1'b1;  bus.reg_dst_2_3 = 1'b1;
        bus.register_write_2_3 = 1'b1;  bus.mem_read_2_3 = 1'b1;
        bus.mem_write_2_3 = 1'b1;  bus.mem_to_reg_2_3 = 1'b1;
        bus.write_back_data_4_5 = 32'h4444_4444;
        step();
        rst = 1'b0;
        chk_on = 1'b1;
        check("rst_alu", bus.alu_result_3_4, 32'd0);
        check("rst_store", bus.store_data_3_4, 32'd0);
        check("rst_rd", {27'b0, bus.rd_3_4}, 32'd0);
        check("rst_flags", {28'b0, bus.register_write_3_4, bus.mem_read_3_4,
                            bus.mem_write_3_4, bus.mem_to_reg_3_4}, 32'd0);

        // ADD without forwarding.
        clear_in();
        bus.data_a_2_3 = 32'd5;  bus.data_b_2_3 = 32'd7;  bus.alu_ctrl_2_3 = 4'd6;
        bus.reg_dst_2_3 = 1'b1;  bus.rd_2_3 = 5'd3;  bus.rt_2_3 = 5'd9;
        bus.register_write_2_3 = 1'b1;
        step();
        check("add_alu", bus.alu_result_3_4, 32'd12);
        check("add_model", exp_alu, 32'd12);
        check("add_rd", {27'b0, bus.rd_3_4}, 32'd3);
        check("add_rw", {31'b0, bus.register_write_3_4}, 32'd1);

        // SUB with operand A forwarded from the latch (stale data_a ignored).
        bus.control_muxA = 2'd1;  bus.data_a_2_3 = 32'd99;  bus.data_b_2_3 = 32'd2;
        bus.alu_ctrl_2_3 = 4'd7;
        step();
        check("fwd_sub", bus.alu_result_3_4, 32'd10);
        check("fwd_sub_model", exp_alu, 32'd10);

        // SLT 0 < -1 with B from WB forwarding.
        bus.control_muxA = 2'd0;  bus.data_a_2_3 = 32'd0;
        bus.control_muxB = 2'd2;  bus.write_back_data_4_5 = 32'hFFFF_FFFF;
        bus.alu_ctrl_2_3 = 4'd12;
        step();
        check("fwd_slt", bus.alu_result_3_4, 32'd0);
        check("fwd_slt_store", bus.store_data_3_4, 32'hFFFF_FFFF);

        // Preload 0x55, then SW-style: immediate address, forwarded store data.
        clear_in();
        bus.data_a_2_3 = 32'h55;  bus.alu_ctrl_2_3 = 4'd6;
        step();
        bus.data_a_2_3 = 32'h100;  bus.alu_src_2_3 = 1'b1;
        bus.sign_ext_2_3 = 32'hFFFF_FFFC;  bus.control_muxB = 2'd1;
        bus.data_b_2_3 = 32'hDEAD_BEEF;  bus.mem_write_2_3 = 1'b1;
        step();
        check("sw_alu", bus.alu_result_3_4, 32'h0000_00FC);
        check("sw_store", bus.store_data_3_4, 32'h55);
        check("sw_mw", {31'b0, bus.mem_write_3_4}, 32'd1);

        // Stall for 3 cycles with changing inputs.
        for (int i = 0; i < 3; i++) begin
            rand_in();
            bus.enable = 1'b0;
            step();
            check("stall_alu", bus.alu_result_3_4, 32'h0000_00FC);
            check("stall_store", bus.store_data_3_4, 32'h55);
        end

        // Flush while enabled loads a bubble.
        rand_in();
        bus.enable = 1'b1;  bus.flush = 1'b1;
        bus.register_write_2_3 = 1'b1;  bus.mem_write_2_3 = 1'b1;
        step();
        check("flush_rd", {27'b0, bus.rd_3_4}, 32'd0);
        check("flush_flags", {28'b0, bus.register_write_3_4, bus.mem_read_3_4,
                              bus.mem_write_3_4, bus.mem_to_reg_3_4}, 32'd0);
        check("flush_alu", bus.alu_result_3_4, 32'd0);

        // Flush while stalled does nothing.
        clear_in();
        bus.data_a_2_3 = 32'd1;  bus.data_b_2_3 = 32'd1;  bus.alu_ctrl_2_3 = 4'd6;
        bus.reg_dst_2_3 = 1'b1;  bus.rd_2_3 = 5'd4;  bus.register_write_2_3 = 1'b1;
        step();
        bus.enable = 1'b0;  bus.flush = 1'b1;
        step();
        check("flush_stall_alu", bus.alu_result_3_4, 32'd2);
        check("flush_stall_rd", {27'b0, bus.rd_3_4}, 32'd4);
        check("flush_stall_rw", {31'b0, bus.register_write_3_4}, 32'd1);

        // Shift boundaries.
        clear_in();
        bus.data_b_2_3 = 32'h8000_0000;  bus.shamt_2_3 = 5'd4;
        bus.alu_ctrl_2_3 = 4'd2;
        step();
        check("sra", bus.alu_result_3_4, 32'hF800_0000);
        check("sra_model", exp_alu, 32'hF800_0000);
        bus.alu_ctrl_2_3 = 4'd1;
        step();
        check("srl", bus.alu_result_3_4, 32'h0800_0000);
        bus.alu_ctrl_2_3 = 4'd3;  bus.data_a_2_3 = 32'd33;
        step();
        check("sllv", bus.alu_result_3_4, 32'h0000_0000);
        bus.alu_ctrl_2_3 = 4'd13;  bus.alu_src_2_3 = 1'b1;  bus.sign_ext_2_3 = 32'h1234;
        step();
        check("lui", bus.alu_result_3_4, 32'h1234_0000);
        check("lui_model", exp_alu, 32'h1234_0000);
        bus.alu_ctrl_2_3 = 4'd15;
        step();
        check("op_f", bus.alu_result_3_4, 32'd0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 500; i++) begin
            rand_in();
            rst = ($urandom_range(0, 99) < 2);
            step();
        end
        rst = 1'b0;
        clear_in();
        step();

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
